mp_add_seq: RTL and testbench

MP_ADD_SEQ -- requirements
Module: mp_add_seq

---
 rtl/mp_add_seq.sv | 121 ++++++++++++
 tb/tb_mp_add_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision adder/subtractor.
// One shared 8-bit ripple adder is stepped across the operand bytes.
module mp_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic                zero,
  output logic                busy
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] res_q;
  logic [KW-1:0]          k_q;
  logic                   cy_q;
  logic                   co_q;
  logic                   ov_q;

  logic [7:0] fa_a;
  logic [7:0] fa_b;
  logic [7:0] fa_s;
  logic [8:0] fa_c;
  logic       accept;
  logic       ack;
  logic       last;

  assign accept = start_valid & (state == IDLE);
  assign ack    = res_ready & (state == DONE);
  assign last   = (k_q == KW'(NBYTES - 1));

  assign fa_a = a_q[k_q];
  assign fa_b = b_q[k_q];

  // The single time-shared 8-bit ripple adder: eight full-adder cells.
  always_comb begin
    fa_s    = '0;
    fa_c    = '0;
    fa_c[0] = cy_q;
    for (int i = 0; i < 8; i++) begin
      fa_s[i]   = fa_a[i] ^ fa_b[i] ^ fa_c[i];
      fa_c[i+1] = (fa_a[i] & fa_b[i])
                | (fa_c[i] & (fa_a[i] ^ fa_b[i]));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic: accept, step bytes, hold until the result is taken.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last)   state_n = DONE;
      DONE:    if (ack)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, per-byte sum/carry update and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      k_q   <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (accept) begin
      a_q  <= op_a;
      b_q  <= op_b ^ {W{sub}};
      cy_q <= sub;
      k_q  <= '0;
    end else if (state == RUN) begin
      res_q[k_q] <= fa_s;
      cy_q       <= fa_c[8];
      if (last) begin
        k_q  <= '0;
        co_q <= fa_c[8];
        ov_q <= fa_c[7] ^ fa_c[8];
      end else begin
        k_q <= k_q + KW'(1);
      end
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign result      = res_q;
  assign carry_out   = co_q;
  assign overflow    = ov_q;
  assign zero        = ~|res_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq at NBYTES=4.
// Covers flags, latency, backpressure, reset abort and back-to-back ops.
module tb_mp_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         busy;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  mp_add_seq #(.NBYTES(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for res_valid; returns edges elapsed (capped).
  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // One full operation: accept, check latency and result, handshake.
  task automatic do_op(input string tag,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic s,
                       input logic [W-1:0] er,
                       input logic ec,
                       input logic ev,
                       input logic ez);
    int n;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    check({tag, ".rdy"}, 64'(start_ready), 64'd1);
    tick();
    start_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    sub  = ~s;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    wait_valid(n);
    check({tag, ".lat"}, 64'(n), 64'(NB));
    check({tag, ".res"}, 64'(result), 64'(er));
    check({tag, ".c"}, 64'(carry_out), 64'(ec));
    check({tag, ".v"}, 64'(overflow), 64'(ev));
    check({tag, ".z"}, 64'(zero), 64'(ez));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, ".ack"}, 64'(res_valid), 64'd0);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
    logic [W:0] t;
    logic       v;
    if (s) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else   t = {1'b0, a} + {1'b0, b};
    if (s) v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
    else   v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {v, t};
  endfunction

  initial begin
    int n;
    int seen;
    int tprev;
    logic [W+1:0] m;

    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    #23;
    check("rst.rdy", 64'(start_ready), 64'd1);
    check("rst.vld", 64'(res_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.res", 64'(result), 64'd0);
    check("rst.c", 64'(carry_out), 64'd0);
    check("rst.v", 64'(overflow), 64'd0);
    check("rst.z", 64'(zero), 64'd1);
    tick();
    rst = 1'b0;

    do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
          32'h0000_0000, 1'b1, 1'b0, 1'b1);
    do_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1,
          32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1,
          32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
          32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_op("add_pln", 32'h1234_5678, 32'h1111_1111, 1'b0,
          32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Backpressure in DONE with a pending request.
    start_valid = 1'b1;
    op_a = 32'h0000_00FF;
    op_b = 32'h0000_0001;
    sub = 1'b0;
    tick();
    start_valid = 1'b0;
    wait_valid(n);
    check("bp.lat", 64'(n), 64'(NB));
    start_valid = 1'b1;
    op_a = 32'h0000_0001;
    op_b = 32'h0000_0002;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.res", 64'(result), 64'h100);
      check("bp.vld", 64'(res_valid), 64'd1);
      check("bp.rdy", 64'(start_ready), 64'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp.idle", 64'(start_ready), 64'd1);
    check("bp.vld0", 64'(res_valid), 64'd0);
    tick();
    start_valid = 1'b0;
    check("bp.acc", 64'(busy), 64'd1);
    wait_valid(n);
    check("bp.lat2", 64'(n), 64'(NB));
    check("bp.res2", 64'(result), 64'h3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset aborts an operation after two bytes.
    start_valid = 1'b1;
    op_a = 32'hAAAA_AAAA;
    op_b = 32'h1111_1111;
    sub = 1'b0;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("ra.rdy", 64'(start_ready), 64'd1);
    check("ra.vld", 64'(res_valid), 64'd0);
    check("ra.busy", 64'(busy), 64'd0);
    check("ra.res", 64'(result), 64'd0);
    check("ra.c", 64'(carry_out), 64'd0);
    check("ra.v", 64'(overflow), 64'd0);
    check("ra.z", 64'(zero), 64'd1);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("ra.novld", 64'(seen), 64'd0);
    do_op("ra.next", 32'h0000_0001, 32'h0000_0001, 1'b0,
          32'h0000_0002, 1'b0, 1'b0, 1'b0);

    // Back-to-back random operations, res_ready tied high.
    res_ready = 1'b1;
    start_valid = 1'b1;
    tprev = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!start_ready && n < 20) begin
        tick();
        n++;
      end
      check("bb.wait", 64'(start_ready), 64'd1);
      op_a = $urandom;
      op_b = $urandom;
      sub  = 1'($urandom);
      if (i == 2) begin
        op_a = 32'h8000_0000;
        op_b = 32'h8000_0000;
        sub  = 1'b0;
      end
      m = model(op_a, op_b, sub);
      tick();
      if (i > 0) check("bb.per", 64'(cyc - tprev), 64'(NB + 2));
      tprev = cyc;
      wait_valid(n);
      check("bb.lat", 64'(n), 64'(NB));
      check("bb.res", 64'(result), 64'(m[W-1:0]));
      check("bb.c", 64'(carry_out), 64'(m[W]));
      check("bb.v", 64'(overflow), 64'(m[W+1]));
      check("bb.z", 64'(zero), 64'(m[W-1:0] == '0));
      tick();
    end
    start_valid = 1'b0;
    res_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
